// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default
// sizing used by the core top level.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read lane: x0 reads zero, optional same-cycle bypass with
// port B (younger) winning over port A, else the stored array value.
module regfile_rdport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            run,
  input  logic [AW-1:0]   ra,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic [XLEN-1:0] regs [NREGS],
  output logic [XLEN-1:0] rd
);

  // A nonzero ra means any matching write address is nonzero too.
  always_comb begin
    rd = '0;
    if (run && ra != '0) begin
      if (BYPASS != 0 && we_b && wa_b == ra) begin
        rd = wd_b;
      end else if (BYPASS != 0 && we_a && wa_a == ra) begin
        rd = wd_a;
      end else begin
        rd = regs[ra];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NRD async read lanes, x0 tied
// to zero, and a post-reset hardware clear that zeroes one entry per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_a,
  input  logic [AW-1:0]       wa_a,
  input  logic [XLEN-1:0]     wd_a,
  input  logic                we_b,
  input  logic [AW-1:0]       wa_b,
  input  logic [XLEN-1:0]     wd_b,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic                ready,
  output logic                wr_conflict
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic            conflict_q, conflict_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            run;

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    clr_idx_q  <= clr_idx_d;
    ready_q    <= ready_d;
    conflict_q <= conflict_d;
    regs_q     <= regs_d;
  end

  // Clear and normal writes are separated by state, so no arbitration exists.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ready_d    = ready_q;
    conflict_d = 1'b0;
    regs_d     = regs_q;
    if (rst) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          regs_d[clr_idx_q] = '0;
          clr_idx_d         = clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
        RUN: begin
          if (we_a && wa_a != '0) regs_d[wa_a] = wd_a;
          if (we_b && wa_b != '0) regs_d[wa_b] = wd_b;
          conflict_d = we_a && we_b && (wa_a == wa_b) && (wa_a != '0);
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  assign run         = (state_q == RUN);
  assign ready       = ready_q;
  assign wr_conflict = conflict_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW),
      .BYPASS(BYPASS)
    ) u_rdport (
      .run (run),
      .ra  (ra[i*AW +: AW]),
      .we_a(we_a),
      .wa_a(wa_a),
      .wd_a(wd_a),
      .we_b(we_b),
      .wa_b(wa_b),
      .wd_b(wd_b),
      .regs(regs_q),
      .rd  (rd[i*XLEN +: XLEN])
    );
  end

endmodule
